// File: rtl/demux3_1_2_buf_pkg.sv
// rtl/demux3_1_2_buf_pkg.sv - shared constants for the buffered 1-to-2 demultiplexer
package demux3_1_2_buf_pkg;

    localparam int W_DEF     = 3;
    localparam int DEPTH_DEF = 2;
    localparam int CNT_W_DEF = 8;

    // Destination encodings carried on in_sel
    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

endpackage

// File: rtl/demux_fifo.sv
// rtl/demux_fifo.sv - per-channel output FIFO with registered full/empty and zeroed empty head
module demux_fifo #(
    parameter int W     = 3,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    // Qualify requests so a stray push on full or pop on empty cannot corrupt state
    logic do_push;
    logic do_pop;

    assign full    = (count_q == DEPTH_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Head word is masked to zero while empty so downstream never sees stale data
    assign dout = empty ? '0 : mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers, discarded asynchronously on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because dout is masked when empty
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/demux3_1_2_buf.sv
// rtl/demux3_1_2_buf.sv - registered 1-to-2 demux with per-output FIFOs; DEMUX_CNT_EN adds delivery counters
module demux3_1_2_buf
    import demux3_1_2_buf_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int DEPTH = DEPTH_DEF
`ifdef DEMUX_CNT_EN
    ,
    parameter int CNT_W = CNT_W_DEF
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_sel,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [W-1:0]     out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [W-1:0]     out1_data
`ifdef DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);

    logic full0, full1;
    logic empty0, empty1;
    logic push0, push1;
    logic pop0, pop1;
    logic accept;

    // Ready looks only at the registered full flag of the chosen FIFO, so a
    // same-cycle pop never opens a slot for the incoming word
    assign in_ready = (in_sel == CH1) ? !full1 : !full0;
    assign accept   = in_valid && in_ready;
    assign push0    = accept && (in_sel == CH0);
    assign push1    = accept && (in_sel == CH1);

    assign out0_valid = !empty0;
    assign out1_valid = !empty1;
    assign pop0       = out0_valid && out0_ready;
    assign pop1       = out1_valid && out1_ready;

    demux_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push0),
        .pop   (pop0),
        .din   (in_data),
        .dout  (out0_data),
        .full  (full0),
        .empty (empty0)
    );

    demux_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push1),
        .pop   (pop1),
        .din   (in_data),
        .dout  (out1_data),
        .full  (full1),
        .empty (empty1)
    );

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    // Delivered-word counters step on each pop and wrap modulo 2^CNT_W
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (pop0) begin
            cnt0_d = cnt0_q + 1'b1;
        end
        if (pop1) begin
            cnt1_d = cnt1_q + 1'b1;
        end
    end

    // Counter registers, cleared with the FIFOs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_demux3_1_2_buf.sv
// tb/tb_demux3_1_2_buf.sv - self-checking bench for demux3_1_2_buf against a queue-based reference model
module tb_demux3_1_2_buf;

    localparam int W     = 3;
    localparam int DEPTH = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_sel;
    logic         out0_valid;
    logic         out0_ready;
    logic [W-1:0] out0_data;
    logic         out1_valid;
    logic         out1_ready;
    logic [W-1:0] out1_data;
`ifdef DEMUX_CNT_EN
    logic [7:0]   cnt0;
    logic [7:0]   cnt1;
`endif

    demux3_1_2_buf dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data)
`ifdef DEMUX_CNT_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: one queue of pending words per channel plus delivery tallies
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    int           m_cnt0;
    int           m_cnt1;
    int           n_checks;
    int           n_passed;
    bit           last_stalled;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic model_ready(input logic sel);
        return sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
    endfunction

    task automatic check_outputs();
        check("out0_valid", 8'(out0_valid), 8'(q0.size() > 0));
        check("out1_valid", 8'(out1_valid), 8'(q1.size() > 0));
        check("out0_data", 8'(out0_data), (q0.size() > 0) ? 8'(q0[0]) : 8'h00);
        check("out1_data", 8'(out1_data), (q1.size() > 0) ? 8'(q1[0]) : 8'h00);
`ifdef DEMUX_CNT_EN
        check("cnt0", cnt0, 8'(m_cnt0 % 256));
        check("cnt1", cnt1, 8'(m_cnt1 % 256));
`endif
    endtask

    // One clock: check ready for the applied inputs, advance model at the edge,
    // then check outputs at the following falling edge
    task automatic step();
        logic rdy;
        logic pop0;
        logic pop1;
        #1;
        rdy = model_ready(in_sel);
        check("in_ready", 8'(in_ready), 8'(rdy));
        @(posedge clk);
        if (rst_n) begin
            pop0 = (q0.size() > 0) && out0_ready;
            pop1 = (q1.size() > 0) && out1_ready;
            if (pop0) begin
                void'(q0.pop_front());
                m_cnt0++;
            end
            if (pop1) begin
                void'(q1.pop_front());
                m_cnt1++;
            end
            if (in_valid && rdy) begin
                if (in_sel) q1.push_back(in_data);
                else        q0.push_back(in_data);
            end
            last_stalled = in_valid && !rdy;
        end else begin
            last_stalled = 1'b0;
        end
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        n_checks     = 0;
        n_passed     = 0;
        m_cnt0       = 0;
        m_cnt1       = 0;
        last_stalled = 1'b0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_sel       = 1'b0;
        out0_ready   = 1'b0;
        out1_ready   = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // Basic routing: 101 to ch0 then 011 to ch1, both consumers ready
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 3'b101;
        step();
        check("first_out0_data", 8'(out0_data), 8'h05);
        in_sel = 1'b1; in_data = 3'b011;
        step();
        check("first_out1_data", 8'(out1_data), 8'h03);
        check("out0_valid_pulse", 8'(out0_valid), 8'h00);
        in_valid = 1'b0;
        step();
        check("out1_valid_pulse", 8'(out1_valid), 8'h00);

        // Fill ch0 with its consumer stalled; third word must be refused
        out0_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 3'b001;
        step();
        in_data = 3'b010;
        step();
        in_data = 3'b100;
        #1;
        check("full0_in_ready", 8'(in_ready), 8'h00);
        step();
        check("full0_head", 8'(out0_data), 8'h01);

        // Ch1 traffic still flows while ch0 is full
        in_sel = 1'b1; in_data = 3'b110;
        step();
        check("ch1_bypass_full0", 8'(out1_data), 8'h06);
        check("ch0_untouched", 8'(out0_data), 8'h01);

        // Pop and push on full ch0: push refused this cycle, accepted the next
        in_sel = 1'b0; in_data = 3'b100; out0_ready = 1'b1;
        step();
        check("full_pop_head", 8'(out0_data), 8'h02);
        step();
        check("retry_accepted", 8'(out0_data), 8'h04);
        in_valid = 1'b0;
        step();
        step();

        // Ten alternating words with both consumers ready, pointers wrap
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_sel   = i[0];
            in_data  = W'($urandom_range(0, 7));
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        check("stream_drained0", 8'(q0.size()), 8'h00);

        // Asynchronous reset between edges with two words buffered
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 3'b111;
        step();
        in_sel = 1'b1; in_data = 3'b010;
        step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        q0.delete();
        q1.delete();
        m_cnt0 = 0;
        m_cnt1 = 0;
        check("async_rst_valid0", 8'(out0_valid), 8'h00);
        check("async_rst_valid1", 8'(out1_valid), 8'h00);
        check("async_rst_data0", 8'(out0_data), 8'h00);
        check("async_rst_data1", 8'(out1_data), 8'h00);
        step();
        rst_n = 1'b1;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        step();

`ifdef DEMUX_CNT_EN
        // 300 deliveries on ch1 wrap an 8-bit counter to 44
        in_valid = 1'b1; in_sel = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_data = W'(i);
            step();
        end
        in_valid = 1'b0;
        step();
        check("cnt1_wrapped", cnt1, 8'd44);
        check("cnt0_idle", cnt0, 8'd0);
`endif

        // Randomized traffic honouring the hold-while-stalled rule
        for (int i = 0; i < 600; i++) begin
            if (!last_stalled) begin
                in_valid = 1'($urandom_range(0, 3) != 0);
                in_sel   = 1'($urandom_range(0, 1));
                in_data  = W'($urandom_range(0, 7));
            end
            out0_ready = 1'($urandom_range(0, 2) != 0);
            out1_ready = 1'($urandom_range(0, 2) == 0);
            step();
        end
        in_valid   = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
        end

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
